// File: rtl/mem_hs_ram.sv
// mem_hs_ram: byte-addressed big-endian RAM with MFA/MFC handshake, programmable
// latency, SPARC V8 load/store sizes and a Trap flag for illegal or misaligned accesses.
module mem_hs_ram #(
    parameter int ADDR_W     = 8,
    parameter int LATENCY    = 3,
    parameter bit LEGACY_LD8 = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              MFA,
    input  logic [5:0]        Opcode,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              MFC,
    output logic              Trap,
    output logic              Busy
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
    state_t            state;
    logic [3:0]        cnt;
    logic [5:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       din_q;
    logic [7:0]        mem [2**ADDR_W];
    logic              legal;
    logic              is_st;
    logic              sgn;
    logic [1:0]        sz;
    logic              fault;
    logic              we;
    logic [ADDR_W-1:0] a1;
    logic [ADDR_W-1:0] a2;
    logic [ADDR_W-1:0] a3;
    logic [31:0]       ld_val;
    // sz: 0 byte, 1 halfword, 2 word
    always_comb begin
        legal = 1'b1;
        is_st = 1'b0;
        sgn   = 1'b0;
        sz    = 2'd2;
        case (op_q)
            6'h00: legal = 1'b1;
            6'h01: sz = 2'd0;
            6'h02: sz = 2'd1;
            6'h09: begin sz = 2'd0; sgn = 1'b1; end
            6'h0A: begin sz = 2'd1; sgn = 1'b1; end
            6'h04: is_st = 1'b1;
            6'h05: begin is_st = 1'b1; sz = 2'd0; end
            6'h06: begin is_st = 1'b1; sz = 2'd1; end
            6'h08: legal = LEGACY_LD8;
            default: legal = 1'b0;
        endcase
    end
    assign fault  = !legal || (sz == 2'd1 && addr_q[0]) || (sz == 2'd2 && |addr_q[1:0]);
    assign we     = state == S_WAIT && MFA && cnt == 4'd0 && is_st && !fault && !Reset;
    assign a1     = addr_q + ADDR_W'(1);
    assign a2     = addr_q + ADDR_W'(2);
    assign a3     = addr_q + ADDR_W'(3);
    assign ld_val = sz == 2'd2 ? {mem[addr_q], mem[a1], mem[a2], mem[a3]} :
                    sz == 2'd1 ? {{16{sgn & mem[addr_q][7]}}, mem[addr_q], mem[a1]} :
                                 {{24{sgn & mem[addr_q][7]}}, mem[addr_q]};
    // Array is deliberately left out of reset; stores land on the completion edge only.
    always_ff @(posedge Clk) begin
        if (we) begin
            mem[addr_q] <= sz == 2'd0 ? din_q[7:0] : sz == 2'd1 ? din_q[15:8] : din_q[31:24];
            if (sz != 2'd0) mem[a1] <= sz == 2'd1 ? din_q[7:0] : din_q[23:16];
            if (sz == 2'd2) begin
                mem[a2] <= din_q[15:8];
                mem[a3] <= din_q[7:0];
            end
        end
    end
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            op_q    <= 6'd0;
            addr_q  <= '0;
            din_q   <= 32'd0;
            DataOut <= 32'd0;
            MFC     <= 1'b0;
            Trap    <= 1'b0;
            Busy    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (MFA) begin
                    op_q   <= Opcode;
                    addr_q <= Address;
                    din_q  <= DataIn;
                    cnt    <= 4'(LATENCY - 1);
                    state  <= S_WAIT;
                    Busy   <= 1'b1;
                end
                S_WAIT: if (!MFA) begin
                    state <= S_IDLE;
                    Busy  <= 1'b0;
                end else if (cnt == 4'd0) begin
                    state <= S_DONE;
                    MFC   <= 1'b1;
                    Trap  <= fault;
                    if (!fault && !is_st) DataOut <= ld_val;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                S_DONE: if (!MFA) begin
                    state <= S_IDLE;
                    MFC   <= 1'b0;
                    Trap  <= 1'b0;
                    Busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_hs_ram.sv
// tb_mem_hs_ram: table-driven scoreboard bench for mem_hs_ram at latencies 3, 1 and 15.
module tb_mem_hs_ram;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  opcode = 6'd0;
    logic [7:0]  address = 8'd0;
    logic [31:0] data_in = 32'd0;
    logic        mfa [3];
    logic        mfc [3];
    logic        trap [3];
    logic        busy [3];
    logic [31:0] dout [3];
    int total = 0;
    int bad = 0;

    typedef struct {
        string       nm;
        logic [31:0] d;
        logic        t;
        int          lat;
    } exp_t;
    exp_t sb [$];

    typedef struct {
        logic [5:0]  op;
        logic [7:0]  a;
        logic [31:0] din;
        logic [31:0] d;
        logic        t;
        string       nm;
    } vec_t;
    vec_t vt [16];

    always #5 clk = ~clk;

    mem_hs_ram #(.ADDR_W(8), .LATENCY(3)) dut0 (
        .Clk(clk), .Reset(rst), .MFA(mfa[0]), .Opcode(opcode), .Address(address), .DataIn(data_in),
        .DataOut(dout[0]), .MFC(mfc[0]), .Trap(trap[0]), .Busy(busy[0]));
    mem_hs_ram #(.ADDR_W(8), .LATENCY(1)) dut1 (
        .Clk(clk), .Reset(rst), .MFA(mfa[1]), .Opcode(opcode), .Address(address), .DataIn(data_in),
        .DataOut(dout[1]), .MFC(mfc[1]), .Trap(trap[1]), .Busy(busy[1]));
    mem_hs_ram #(.ADDR_W(8), .LATENCY(15)) dut2 (
        .Clk(clk), .Reset(rst), .MFA(mfa[2]), .Opcode(opcode), .Address(address), .DataIn(data_in),
        .DataOut(dout[2]), .MFC(mfc[2]), .Trap(trap[2]), .Busy(busy[2]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // One full handshake; operands are scrambled right after capture to prove they were latched.
    task automatic access(input int idx, input logic [5:0] op, input logic [7:0] a, input logic [31:0] d,
                          input logic [31:0] exp_d, input logic exp_t_, input int exp_lat, input string nm);
        int n;
        exp_t e;
        sb.push_back('{nm, exp_d, exp_t_, exp_lat});
        opcode  = op;
        address = a;
        data_in = d;
        mfa[idx] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk({nm, "_busy"}, 32'(busy[idx]), 32'd1);
                opcode  = 6'h05;
                address = ~a;
                data_in = ~d;
            end
        end while (!mfc[idx] && n < 40);
        e = sb.pop_front();
        if (!mfc[idx]) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no MFC want MFC within %0d edges", e.nm, e.lat);
        end else begin
            chk({e.nm, "_lat"}, 32'(n - 1), 32'(e.lat));
            chk({e.nm, "_dout"}, dout[idx], e.d);
            chk({e.nm, "_trap"}, 32'(trap[idx]), 32'(e.t));
        end
        mfa[idx] = 1'b0;
        @(negedge clk);
        chk({nm, "_release"}, {30'd0, mfc[idx], busy[idx]}, 32'd0);
    endtask

    initial begin
        int quiet;
        vt[0]  = '{6'h04, 8'h10, 32'hA2044012, 32'h00000000, 1'b0, "st_word"};
        vt[1]  = '{6'h00, 8'h10, 32'h0,        32'hA2044012, 1'b0, "ld_word"};
        vt[2]  = '{6'h09, 8'h10, 32'h0,        32'hFFFFFFA2, 1'b0, "ldsb"};
        vt[3]  = '{6'h01, 8'h13, 32'h0,        32'h00000012, 1'b0, "ldub"};
        vt[4]  = '{6'h02, 8'h12, 32'h0,        32'h00004012, 1'b0, "lduh"};
        vt[5]  = '{6'h0A, 8'h10, 32'h0,        32'hFFFFA204, 1'b0, "ldsh"};
        vt[6]  = '{6'h0A, 8'h12, 32'h0,        32'h00004012, 1'b0, "ldsh_pos"};
        vt[7]  = '{6'h05, 8'h11, 32'h000000FF, 32'h00004012, 1'b0, "stb"};
        vt[8]  = '{6'h00, 8'h10, 32'h0,        32'hA2FF4012, 1'b0, "ld_after_stb"};
        vt[9]  = '{6'h00, 8'h02, 32'h0,        32'hA2FF4012, 1'b1, "ld_misalign"};
        vt[10] = '{6'h06, 8'h13, 32'h0000BEEF, 32'hA2FF4012, 1'b1, "sth_misalign"};
        vt[11] = '{6'h00, 8'h10, 32'h0,        32'hA2FF4012, 1'b0, "ld_after_sth"};
        vt[12] = '{6'h3F, 8'h10, 32'h0,        32'hA2FF4012, 1'b1, "illegal_op"};
        vt[13] = '{6'h04, 8'h20, 32'h11223344, 32'hA2FF4012, 1'b0, "st_0x20"};
        vt[14] = '{6'h08, 8'h20, 32'h0,        32'h11223344, 1'b0, "legacy_ld8"};
        vt[15] = '{6'h01, 8'h11, 32'h0,        32'h000000FF, 1'b0, "ldub_ff"};
        for (int i = 0; i < 3; i++) mfa[i] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk($sformatf("reset_%0d", i), dout[i] | {28'd0, mfc[i], trap[i], busy[i], 1'b0}, 32'd0);
        for (int i = 0; i < 16; i++)
            access(0, vt[i].op, vt[i].a, vt[i].din, vt[i].d, vt[i].t, 3, vt[i].nm);
        // Abort: MFA dropped one edge after capture of a store.
        opcode = 6'h04; address = 8'h20; data_in = 32'hDEADBEEF; mfa[0] = 1'b1;
        @(negedge clk);
        mfa[0] = 1'b0;
        quiet = 0;
        repeat (6) begin
            @(negedge clk);
            quiet += int'(mfc[0]);
        end
        chk("abort_no_mfc", 32'(quiet), 32'd0);
        chk("abort_busy", 32'(busy[0]), 32'd0);
        access(0, 6'h00, 8'h20, 32'h0, 32'h11223344, 1'b0, 3, "ld_after_abort");
        // Asynchronous reset in WAIT of a store.
        opcode = 6'h04; address = 8'h20; data_in = 32'h55667788; mfa[0] = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_mid_outs", dout[0] | {28'd0, mfc[0], trap[0], busy[0], 1'b0}, 32'd0);
        mfa[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        access(0, 6'h00, 8'h20, 32'h0, 32'h11223344, 1'b0, 3, "ld_after_rst");
        // Latency sweep on the LATENCY=1 and LATENCY=15 instances.
        access(1, 6'h04, 8'h10, 32'hA2044012, 32'h0, 1'b0, 1, "lat1_st");
        access(1, 6'h00, 8'h10, 32'h0, 32'hA2044012, 1'b0, 1, "lat1_ld");
        access(2, 6'h04, 8'h10, 32'hA2044012, 32'h0, 1'b0, 15, "lat15_st");
        access(2, 6'h00, 8'h10, 32'h0, 32'hA2044012, 1'b0, 15, "lat15_ld");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
